// File: rtl/operand_fetch.sv
`default_nettype none
// ============================================================================
//  Module      : operand_fetch
//  Description : Pipeline stage between decode and execute. Accepts a decoded
//                instruction, reads both source operands from the register
//                file, and presents a registered operand bundle to execute.
//                Owns both register file ports: port A carries writebacks from
//                execute (absolute priority) and otherwise reads source A;
//                port B always reads source B. A per-register pending-write
//                scoreboard stalls RAW and WAW hazards, and writeback data is
//                forwarded into the bundle in the cycle it is written.
//
//  Ports       : Clock, Reset        - clock, synchronous active-high reset
//                InValid/InReady     - instruction handshake from decode
//                SrcA, SrcB, DestIn  - register indices of the instruction
//                UsesDest, OpIn      - destination-write flag and opcode
//                OutValid/OutReady   - operand bundle handshake to execute
//                OperandA, OperandB  - fetched (or forwarded) operands
//                DestOut, OpOut,
//                UsesDestOut         - registered pass-through fields
//                WbValid, WbAddress,
//                WbData              - writeback request (always accepted)
//                RfAddressA, RfWriteData, RfWriteEnable, RfReadDataA
//                                    - register file port A (read/write)
//                RfAddressB, RfReadDataB
//                                    - register file port B (read-only)
//
//  Revision    : 1.0 - initial release
// ============================================================================
module operand_fetch #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 6,
    parameter int OP_WIDTH   = 4
) (
    input  logic                  Clock,
    input  logic                  Reset,

    // Decode side
    input  logic                  InValid,
    output logic                  InReady,
    input  logic [ADDR_WIDTH-1:0] SrcA,
    input  logic [ADDR_WIDTH-1:0] SrcB,
    input  logic [ADDR_WIDTH-1:0] DestIn,
    input  logic                  UsesDest,
    input  logic [OP_WIDTH-1:0]   OpIn,

    // Execute side
    output logic                  OutValid,
    input  logic                  OutReady,
    output logic [DATA_WIDTH-1:0] OperandA,
    output logic [DATA_WIDTH-1:0] OperandB,
    output logic [ADDR_WIDTH-1:0] DestOut,
    output logic [OP_WIDTH-1:0]   OpOut,
    output logic                  UsesDestOut,

    // Writeback from execute
    input  logic                  WbValid,
    input  logic [ADDR_WIDTH-1:0] WbAddress,
    input  logic [DATA_WIDTH-1:0] WbData,

    // Register file
    output logic [ADDR_WIDTH-1:0] RfAddressA,
    output logic [DATA_WIDTH-1:0] RfWriteData,
    output logic                  RfWriteEnable,
    input  logic [DATA_WIDTH-1:0] RfReadDataA,
    output logic [ADDR_WIDTH-1:0] RfAddressB,
    input  logic [DATA_WIDTH-1:0] RfReadDataB
);

    localparam int c_NUM_REGS = 2 ** ADDR_WIDTH;

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [c_NUM_REGS-1:0] r_busy;
    logic                  r_outValid;
    logic [DATA_WIDTH-1:0] r_operandA;
    logic [DATA_WIDTH-1:0] r_operandB;
    logic [ADDR_WIDTH-1:0] r_destOut;
    logic [OP_WIDTH-1:0]   r_opOut;
    logic                  r_usesDestOut;

    // ------------------------------------------------------------------------
    // Combinational hazard resolution
    // ------------------------------------------------------------------------
    logic                  w_wbHitA;
    logic                  w_wbHitB;
    logic                  w_wbHitDest;
    logic                  w_availA;
    logic                  w_availB;
    logic                  w_destOk;
    logic                  w_slotFree;
    logic                  w_inReady;
    logic                  w_accept;
    logic [DATA_WIDTH-1:0] w_dataA;
    logic [DATA_WIDTH-1:0] w_dataB;
    logic [c_NUM_REGS-1:0] w_clearMask;
    logic [c_NUM_REGS-1:0] w_setMask;
    logic [c_NUM_REGS-1:0] w_busyNext;

    assign w_wbHitA    = WbValid && (SrcA == WbAddress);
    assign w_wbHitB    = WbValid && (SrcB == WbAddress);
    assign w_wbHitDest = WbValid && (DestIn == WbAddress);

    // Port A is stolen by any writeback; the only way to still obtain operand
    // A in that cycle is when the writeback targets SrcA itself. A matching
    // writeback also supersedes a pending entry, since it is that very write.
    assign w_availA = WbValid ? w_wbHitA : !r_busy[SrcA];
    assign w_dataA  = w_wbHitA ? WbData : RfReadDataA;

    // Port B is never stolen, so only the scoreboard can block it.
    assign w_availB = w_wbHitB || !r_busy[SrcB];
    assign w_dataB  = w_wbHitB ? WbData : RfReadDataB;

    // A second writer to a pending register must wait until the first one
    // retires (at the latest in the same cycle as its writeback).
    assign w_destOk   = !UsesDest || !r_busy[DestIn] || w_wbHitDest;
    assign w_slotFree = !r_outValid || OutReady;

    // Deliberately independent of InValid so decode may look at it first.
    assign w_inReady = w_availA && w_availB && w_destOk && w_slotFree;
    assign w_accept  = InValid && w_inReady;

    // Scoreboard update: clear on writeback, set on accept; set is applied
    // last so that it wins on a same-cycle collision.
    always_comb begin
        w_clearMask = '0;
        w_setMask   = '0;
        if (WbValid) begin
            w_clearMask[WbAddress] = 1'b1;
        end
        if (w_accept && UsesDest) begin
            w_setMask[DestIn] = 1'b1;
        end
    end

    assign w_busyNext = (r_busy & ~w_clearMask) | w_setMask;

    // ------------------------------------------------------------------------
    // Register file port arbitration
    // ------------------------------------------------------------------------
    assign RfAddressA    = WbValid ? WbAddress : SrcA;
    assign RfWriteData   = WbData;
    assign RfWriteEnable = WbValid;
    assign RfAddressB    = SrcB;

    // ------------------------------------------------------------------------
    // Sequential state
    // ------------------------------------------------------------------------
    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_busy        <= '0;
            r_outValid    <= 1'b0;
            r_operandA    <= '0;
            r_operandB    <= '0;
            r_destOut     <= '0;
            r_opOut       <= '0;
            r_usesDestOut <= 1'b0;
        end else begin
            r_busy <= w_busyNext;
            if (w_accept) begin
                r_outValid    <= 1'b1;
                r_operandA    <= w_dataA;
                r_operandB    <= w_dataB;
                r_destOut     <= DestIn;
                r_opOut       <= OpIn;
                r_usesDestOut <= UsesDest;
            end else if (OutReady) begin
                // Bundle consumed with nothing to replace it; payload holds.
                r_outValid <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign InReady     = w_inReady;
    assign OutValid    = r_outValid;
    assign OperandA    = r_operandA;
    assign OperandB    = r_operandB;
    assign DestOut     = r_destOut;
    assign OpOut       = r_opOut;
    assign UsesDestOut = r_usesDestOut;

endmodule
`default_nettype wire
